// File: rtl/dw_norm_seq.sv
// rtl/dw_norm_seq.sv - multi-cycle leading-one normaliser with exponent adjust and valid/ready handshakes
module dw_norm_seq #(
  parameter int A_WIDTH    = 16,
  parameter int SRCH_WIND  = 16,
  parameter int EXP_WIDTH  = 5,
  parameter int SHIFT_STEP = 4,
  parameter int EXP_CTR    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [EXP_WIDTH-1:0] exp_offset,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_WIDTH-1:0]   b,
  output logic [EXP_WIDTH-1:0] exp_adj,
  output logic                 no_detect,
  output logic                 ovfl
);

  localparam int CW = $clog2(SRCH_WIND);
  // One spare bit above the wider of exponent and count holds the carry/borrow.
  localparam int SW = ((EXP_WIDTH > CW) ? EXP_WIDTH : CW) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_next;
  logic [A_WIDTH-1:0]   val, val_next;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [CW-1:0]        cnt, cnt_next;
  logic [SW-1:0]        sum, diff;
  logic                 finish;
  int                   lz, k, room;

  // Leading-zero count of the working value; an all-zero value counts as A_WIDTH.
  always_comb begin
    lz = A_WIDTH;
    for (int i = 0; i < A_WIDTH; i++) begin
      if (val[i]) lz = A_WIDTH - 1 - i;
    end
  end

  // One shift step: limited by the zeros present, the per-cycle step and the window left.
  always_comb begin
    room = SRCH_WIND - 1 - int'(cnt);
    k = lz;
    if (SHIFT_STEP < k) k = SHIFT_STEP;
    if (room < k) k = room;
    val_next = val << k;
    cnt_next = cnt + CW'(k);
    finish   = val_next[A_WIDTH-1] || (cnt_next == CW'(SRCH_WIND - 1));
    sum      = SW'(exp_r) + SW'(cnt_next);
    diff     = SW'(exp_r) - SW'(cnt_next);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; handshake outputs depend on the state register only.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (finish) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operand, shift it, and register results on the way into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      val       <= '0;
      exp_r     <= '0;
      cnt       <= '0;
      b         <= '0;
      exp_adj   <= '0;
      no_detect <= 1'b0;
      ovfl      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            val   <= a;
            exp_r <= exp_offset;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          val <= val_next;
          cnt <= cnt_next;
          if (finish) begin
            b         <= val_next;
            no_detect <= ~val_next[A_WIDTH-1];
            if (EXP_CTR != 0) begin
              exp_adj <= diff[EXP_WIDTH-1:0];
              ovfl    <= diff[SW-1];
            end else begin
              exp_adj <= sum[EXP_WIDTH-1:0];
              ovfl    <= |sum[SW-1:EXP_WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
